dt_bitmap_pack: RTL and testbench
=================================

Name: dt_bitmap_pack

Overview:
- Converts an 8-bit distance-transform result map (res memory, 128x128 pixels) back into a packed 1-bit object bitmap (sti format: 1024 words x 16 bits).
- Runs the memory interfaces in the opposite direction to the DT engine: it reads the res memory and writes the sti memory.
- Sits after DT in the image pipeline and feeds re-binarised masks back to the DT input ROM image, or to downstream consumers.
- Also reports the object-pixel population count.

Parameters:
- THRESH, 1, a pixel is an object (bit=1) when res_di >= THRESH (unsigned 8-bit compare).
- PIX_CNT, 16384, pixels per image. Fixed by the shared package; not for override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin packing. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the last word is written.
- res_rd  out  1  read strobe to the result RAM.
- res_addr  out  14  pixel address (row*128 + col).
- res_di  in  8  read data, valid exactly 1 cycle after res_rd.
- sti_wr  out  1  write strobe to the bitmap memory.
- sti_addr  out  10  word address.
- sti_do  out  16  packed word. Pixel 16*w+k maps to sti_do[k] of word w.
- obj_count  out  15  number of object pixels (0..16384). Valid from the done cycle and held until the next start.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM to IDLE, counters and shift register cleared. Applies mid-operation too: no further res_rd/sti_wr after the reset edge.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: when start=1, go to READ, clear obj_count and the address counter. Cycle of accept = cycle 0.
- READ: res_rd=1 every cycle; res_addr = rd_ptr, incrementing 0..16383, one pixel per cycle. Pixel a is read in cycle 1+a. After rd_ptr=16383, go to DRAIN.
- DRAIN: lasts 2 cycles; res_rd=0. Flushes the final sample and write. Then go to DONE.
- DONE: done=1 for one cycle, busy=1; next state IDLE.
- Sample pipeline:
  - A registered valid bit tracks res_rd.
  - In the cycle res_di is valid (2+a), bit b = (res_di >= THRESH) shifts into packing register position a[3:0].
  - obj_count increments by b.
- Write: sti_wr, sti_addr and sti_do are registered. They are asserted for one cycle in the cycle after bit 15 of word w is sampled, i.e. cycle 18+16w. sti_addr = w, with w 0..1023, wrapping never occurs. The packing register clears on every write.
- Total latency from start acceptance to done: last write at cycle 16386, done at cycle 16387.
- start while busy: ignored, with no restart.
- start in the done cycle: ignored; it is accepted only from IDLE.
- Arithmetic:
  - rd_ptr is 14-bit and stops at 16383; it is not incremented past.
  - obj_count is 15-bit so it holds 16384 without overflow.
- res_addr is 0 whenever res_rd=0. sti_addr and sti_do are 0 whenever sti_wr=0.

Decomposition:
- Shared package dt_pkg (also used by DT):
  - IMG_W=128, PIX_CNT=16384, WORD_BITS=16, WORD_CNT=1024.
  - RES_AW=14, STI_AW=10, PIX_W=8.
  - State enum for this block.
- One natural sub-module: dt_bit_packer. It takes serial bit + valid + bit index and produces a 16-bit word + word_valid + word index. It contains the packing register and the write-output registers.
- The FSM, address counter and obj_count stay in the top.

Test Plan:
- All-zero res map, start at cycle 0 -> 1024 writes, each sti_do=0x0000, sti_addr 0..1023 at cycles 18+16w; done at cycle 16387; obj_count=0.
- All pixels=5 -> every sti_do=0xFFFF; obj_count=16384 (0x4000); no res_rd after cycle 16384.
- Single pixel addr 17 = 1, rest 0 -> word 1 = 0x0002, all others 0x0000; obj_count=1.
- THRESH=3, pixel value = addr mod 8 -> every word 0xF8F8; obj_count=10240.
- Reset asserted at cycle 500 -> from cycle 501 all outputs 0, no writes; a new start then completes normally with done 16387 cycles after the new accept.
- start pulsed at cycles 0 and 1000 -> single run only: exactly 1024 writes and one done pulse.

Source files
------------

// File: rtl/dt_pkg.sv
// ----------------------------------------------------------------------
// dt_pkg : geometry, widths and FSM encoding shared by the DT blocks
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package dt_pkg;

  localparam int IMG_W     = 128;
  localparam int PIX_CNT   = 16384;
  localparam int WORD_BITS = 16;
  localparam int WORD_CNT  = 1024;

  localparam int RES_AW    = 14;
  localparam int STI_AW    = 10;
  localparam int PIX_W     = 8;
  localparam int BIT_IW    = 4;
  localparam int CNT_W     = RES_AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bp_state_t;

endpackage

`default_nettype wire

// File: rtl/dt_bitmap_pack_if.sv
// ----------------------------------------------------------------------
// dt_bitmap_pack_if : control, res-read and sti-write signals of the packer
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface dt_bitmap_pack_if;
  import dt_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 res_rd;
  logic [RES_AW-1:0]    res_addr;
  logic [PIX_W-1:0]     res_di;
  logic                 sti_wr;
  logic [STI_AW-1:0]    sti_addr;
  logic [WORD_BITS-1:0] sti_do;
  logic [CNT_W-1:0]     obj_count;

  // master: the packing block itself, which drives both memory buses
  modport master (
    input  start, res_di,
    output busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_count
  );

  modport slave (
    output start, res_di,
    input  busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_count
  );

endinterface

`default_nettype wire

// File: rtl/dt_bit_packer.sv
// ----------------------------------------------------------------------
// dt_bit_packer : gathers serial object bits into 16-bit registered words
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module dt_bit_packer
  import dt_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 i_bit,
  input  wire logic                 i_vld,
  input  wire logic [RES_AW-1:0]    i_idx,
  output logic                      o_vld,
  output logic [STI_AW-1:0]         o_idx,
  output logic [WORD_BITS-1:0]      o_word
);

  logic [WORD_BITS-1:0] r_pack;
  logic [WORD_BITS-1:0] r_word;
  logic [STI_AW-1:0]    r_idx;
  logic                 r_vld;
  logic [WORD_BITS-1:0] w_mask;

  assign w_mask = i_bit ? (WORD_BITS'(1) << i_idx[BIT_IW-1:0]) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pack <= '0;
      r_word <= '0;
      r_idx  <= '0;
      r_vld  <= 1'b0;
    end else begin
      // write outputs stay zero except in the single write cycle
      r_vld  <= 1'b0;
      r_word <= '0;
      r_idx  <= '0;
      if (i_vld) begin
        if (&i_idx[BIT_IW-1:0]) begin
          r_vld  <= 1'b1;
          r_word <= r_pack | w_mask;
          r_idx  <= i_idx[RES_AW-1:BIT_IW];
          r_pack <= '0;
        end else begin
          r_pack <= r_pack | w_mask;
        end
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_idx  = r_idx;
  assign o_word = r_word;

endmodule

`default_nettype wire

// File: rtl/dt_bitmap_pack.sv
// ----------------------------------------------------------------------
// dt_bitmap_pack : re-binarises the 8-bit res map into the packed sti bitmap
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module dt_bitmap_pack
  import dt_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESH = 8'd1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dt_bitmap_pack_if.master bus
);

  localparam logic [RES_AW-1:0] c_last_pix = RES_AW'(PIX_CNT - 1);

  bp_state_t          r_state;
  logic [RES_AW-1:0]  r_ptr;
  logic [RES_AW-1:0]  r_smp_idx;
  logic               r_rd;
  logic               r_smp_vld;
  logic               r_busy;
  logic               r_done;
  logic               r_drain;
  logic [CNT_W-1:0]   r_count;
  logic               w_bit;

  assign w_bit = (bus.res_di >= THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_smp_idx <= '0;
      r_rd      <= 1'b0;
      r_smp_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_drain   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_done    <= 1'b0;
      // read data returns one cycle after the strobe
      r_smp_vld <= r_rd;
      r_smp_idx <= r_ptr;

      if (r_state == ST_IDLE && bus.start) begin
        r_count <= '0;
      end else if (r_smp_vld && w_bit) begin
        r_count <= r_count + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_READ;
            r_rd    <= 1'b1;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          if (r_ptr == c_last_pix) begin
            // pointer parks at zero so res_addr reads 0 while idle
            r_state <= ST_DRAIN;
            r_rd    <= 1'b0;
            r_ptr   <= '0;
            r_drain <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dt_bit_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .i_bit  (w_bit),
    .i_vld  (r_smp_vld),
    .i_idx  (r_smp_idx),
    .o_vld  (bus.sti_wr),
    .o_idx  (bus.sti_addr),
    .o_word (bus.sti_do)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.res_rd    = r_rd;
  assign bus.res_addr  = r_ptr;
  assign bus.obj_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_dt_bitmap_pack.sv
// ----------------------------------------------------------------------
// tb_dt_bitmap_pack : scoreboard bench, two instances (THRESH 1 and 3)
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_dt_bitmap_pack;
  import dt_pkg::*;

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [14:0] cnt;
  } dn_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   gcyc  = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t_start = 0, t_end = 0, rd_end = 0, rst_chk = 2;
  bit   final_chk = 1'b0, final_done = 1'b0;
  int   nwr  [2];
  int   viol [2];
  logic [7:0] mem [0:PIX_CNT-1];
  wr_t  qa[$], qb[$];
  dn_t  da[$], db[$];

  dt_bitmap_pack_if bus_a ();
  dt_bitmap_pack_if bus_b ();

  dt_bitmap_pack #(.THRESH(8'd1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  dt_bitmap_pack #(.THRESH(8'd3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  // synchronous res RAM shared by both instances
  always @(posedge clk) begin
    if (bus_a.res_rd) bus_a.res_di <= mem[bus_a.res_addr];
    if (bus_b.res_rd) bus_b.res_di <= mem[bus_b.res_addr];
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, gcyc);
    end
  endtask

  task automatic mon(input int d, input logic bsy, input logic dn, input logic rd,
                     input logic [13:0] ra, input logic wr, input logic [9:0] wa,
                     input logic [15:0] wd, input logic [14:0] oc);
    wr_t  e;
    dn_t  x;
    logic eb, er;
    if (gcyc == rst_chk)
      cmp("reset_outputs", 64'({bsy, dn, rd, ra, wr, wa, wd, oc}), 64'd0);
    eb = (gcyc > t_start) && (gcyc <= t_end);
    er = (gcyc > t_start) && (gcyc <= rd_end);
    if (bsy !== eb || rd !== er ||
        (rd ? (ra !== 14'(gcyc - t_start - 1)) : (ra !== 14'd0)) ||
        (!wr && (wa !== 10'd0 || wd !== 16'd0)))
      viol[d]++;
    if (wr) begin
      nwr[d]++;
      if ((d == 0 ? qa.size() : qb.size()) == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL write_%0d: got addr %0d data %h at cycle %0d, required no write", d, wa, wd, gcyc);
      end else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        cmp(d == 0 ? "write_a" : "write_b", 64'({32'(gcyc), wa, wd}), 64'(e));
      end
    end
    if (dn) begin
      if ((d == 0 ? da.size() : db.size()) == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_%0d: got done at cycle %0d, required none", d, gcyc);
      end else begin
        x = (d == 0) ? da.pop_front() : db.pop_front();
        cmp(d == 0 ? "done_cyc_count_a" : "done_cyc_count_b", 64'({32'(gcyc), oc}), 64'(x));
      end
      cmp("write_total", 64'(nwr[d]), 64'd1024);
      cmp("protocol", 64'(viol[d]), 64'd0);
      nwr[d]  = 0;
      viol[d] = 0;
    end
    if (reset) nwr[d] = 0;
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.busy, bus_a.done, bus_a.res_rd, bus_a.res_addr,
        bus_a.sti_wr, bus_a.sti_addr, bus_a.sti_do, bus_a.obj_count);
    mon(1, bus_b.busy, bus_b.done, bus_b.res_rd, bus_b.res_addr,
        bus_b.sti_wr, bus_b.sti_addr, bus_b.sti_do, bus_b.obj_count);
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      cmp("pending_writes_a", 64'(qa.size()), 64'd0);
      cmp("pending_writes_b", 64'(qb.size()), 64'd0);
      cmp("pending_done_a", 64'(da.size()), 64'd0);
      cmp("pending_done_b", 64'(db.size()), 64'd0);
      cmp("protocol_tail_a", 64'(viol[0]), 64'd0);
      cmp("protocol_tail_b", 64'(viol[1]), 64'd0);
    end
  end

  task automatic set_start(input logic v);
    bus_a.start = v;
    bus_b.start = v;
  endtask

  task automatic wait_until(input int c);
    while (gcyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start_at(input int c);
    wait_until(c);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
  endtask

  // Reference: word w bit k is set when pixel 16w+k reaches the threshold
  task automatic push_expect(input int T, input int abort_at);
    wr_t         e;
    dn_t         x;
    int          thr, cnt;
    logic [15:0] word;
    for (int d = 0; d < 2; d++) begin
      thr = (d == 0) ? 1 : 3;
      cnt = 0;
      for (int w = 0; w < WORD_CNT; w++) begin
        word = 16'h0000;
        for (int k = 0; k < WORD_BITS; k++)
          if (int'(mem[WORD_BITS*w + k]) >= thr) begin
            word[k] = 1'b1;
            cnt++;
          end
        e.cyc  = 32'(T + 18 + 16*w);
        e.addr = 10'(w);
        e.data = word;
        if (abort_at == 0 || 18 + 16*w <= abort_at) begin
          if (d == 0) qa.push_back(e);
          else        qb.push_back(e);
        end
      end
      x.cyc = 32'(T + 16387);
      x.cnt = 15'(cnt);
      if (abort_at == 0) begin
        if (d == 0) da.push_back(x);
        else        db.push_back(x);
      end
    end
  endtask

  task automatic do_run(input int abort_at, input int extra_at);
    int T;
    @(posedge clk);
    #1;
    T       = gcyc;
    t_start = T;
    if (abort_at > 0) begin
      t_end   = T + abort_at;
      rd_end  = T + abort_at;
      rst_chk = T + abort_at + 1;
    end else begin
      t_end  = T + 16387;
      rd_end = T + 16384;
    end
    push_expect(T, abort_at);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    if (extra_at > 0) pulse_start_at(T + extra_at);
    if (abort_at > 0) begin
      wait_until(T + abort_at);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_until(T + abort_at + 4);
    end else begin
      wait_until(T + 16392);
    end
  endtask

  initial begin
    set_start(1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // one object pixel: THRESH 3 instance sees an all-zero map
    for (int i = 0; i < PIX_CNT; i++) mem[i] = 8'd0;
    mem[17] = 8'd1;
    do_run(0, 1000);

    for (int i = 0; i < PIX_CNT; i++) mem[i] = 8'd5;
    do_run(0, 16387);

    for (int i = 0; i < PIX_CNT; i++) mem[i] = 8'(i % 8);
    do_run(0, 0);

    for (int i = 0; i < PIX_CNT; i++) mem[i] = 8'($urandom_range(0, 5));
    do_run(500, 0);
    do_run(0, 0);

    final_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
